// File: rtl/button_event_gen.sv
// button_event_gen
//   Turns the debounced level of one push-button into single-cycle event
//   pulses for the clock/calendar setting logic. There is one instance per
//   button.
//
//   Events produced:
//     - a step on every press,
//     - a short pulse on release before the long threshold,
//     - a long pulse when the hold time reaches LONG_CYCLES,
//     - optional auto-repeat steps every REPEAT_CYCLES in the long-hold state.
//
//   Optional feature: define BTN_AUTOREPEAT_EN to enable auto-repeat.
//   Without it, the LONG state only waits for release and REPEAT_CYCLES is
//   unused.
//
//   Ports:
//     clk_i    system clock
//     rst_i    asynchronous active-high reset
//     btn_i    debounced button level, synchronous to clk_i, 1 = pressed
//     step_o   one-cycle pulse on press (plus auto-repeat pulses)
//     short_o  one-cycle pulse on release before the long threshold
//     long_o   one-cycle pulse when the long threshold is reached
//     held_o   level, high while a press is in progress
module button_event_gen #(
  parameter int unsigned LONG_CYCLES   = 100_000_000,
  parameter int unsigned REPEAT_CYCLES = 20_000_000,
  parameter int unsigned CTR_W         = 27
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic step_o,
  output logic short_o,
  output logic long_o,
  output logic held_o
);

  // Elaboration-time parameter sanity checks.
  if (LONG_CYCLES < 2) begin : g_chk_long_min
    $error("LONG_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_chk_rep_min
    $error("REPEAT_CYCLES must be >= 2");
  end
  if (((LONG_CYCLES - 1) >> CTR_W) != 0) begin : g_chk_long_fit
    $error("CTR_W too narrow for LONG_CYCLES");
  end
  if (((REPEAT_CYCLES - 1) >> CTR_W) != 0) begin : g_chk_rep_fit
    $error("CTR_W too narrow for REPEAT_CYCLES");
  end

  localparam logic [CTR_W-1:0] LONG_LAST = CTR_W'(LONG_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CTR_W-1:0] REPEAT_LAST = CTR_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  state_t             state;
  logic [CTR_W-1:0]   ctr;
  logic               btn_prev_r;
  logic               rise;

  // Only rising edges start a press. A release is detected from the level
  // directly, so the falling-edge term is not needed.
  assign rise = btn_i & ~btn_prev_r;

  // btn_prev_r resets to 1 so that a button held across reset release is
  // ignored until it has been released and pressed again.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      ctr        <= '0;
      btn_prev_r <= 1'b1;
      step_o     <= 1'b0;
      short_o    <= 1'b0;
      long_o     <= 1'b0;
      held_o     <= 1'b0;
    end else begin
      btn_prev_r <= btn_i;
      step_o     <= 1'b0;
      short_o    <= 1'b0;
      long_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state  <= PRESS;
            ctr    <= '0;
            step_o <= 1'b1;
            held_o <= 1'b1;
          end
        end
        PRESS: begin
          // A release on the threshold edge wins over the long event.
          if (!btn_i) begin
            state   <= IDLE;
            short_o <= 1'b1;
            held_o  <= 1'b0;
          end else if (ctr == LONG_LAST) begin
            state  <= LONG;
            ctr    <= '0;
            long_o <= 1'b1;
          end else begin
            ctr <= ctr + CTR_W'(1);
          end
        end
        LONG: begin
          if (!btn_i) begin
            state  <= IDLE;
            held_o <= 1'b0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (ctr == REPEAT_LAST) begin
            ctr    <= '0;
            step_o <= 1'b1;
          end else begin
            ctr <= ctr + CTR_W'(1);
          end
`endif
        end
        default: begin
          state  <= IDLE;
          held_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
module tb_button_event_gen;

  localparam int L = 10;
  localparam int R = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic btn_i = 1'b0;
  logic step_o, short_o, long_o, held_o;

  int checks = 0;
  int errors = 0;

  // Expected {step, short, long, held}, pushed when the stimulus is driven
  // and popped when the corresponding clock edge has been sampled.
  logic [3:0] sb[$];

  button_event_gen #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .CTR_W        (8)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (btn_i),
    .step_o (step_o),
    .short_o(short_o),
    .long_o (long_o),
    .held_o (held_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected outputs after edge e of a press whose rise is edge 0 and whose
  // button is sampled high on edges 0..n-1 and low on edge n.
  function automatic logic [3:0] exp_at(input int e, input int n);
    logic st, sh, lg, hd;
    st = (e == 0);
`ifdef BTN_AUTOREPEAT_EN
    if (e < n && e >= L + R && ((e - L) % R) == 0) st = 1'b1;
`endif
    lg = (e == L) && (e < n);
    sh = (e == n) && (n <= L);
    hd = (e < n);
    return {st, sh, lg, hd};
  endfunction

  task automatic check_now(input string tag, input logic [3:0] exp_v);
    logic [3:0] obs;
    obs = {step_o, short_o, long_o, held_o};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic cycle(input logic b, input logic [3:0] exp_v, input string tag);
    logic [3:0] e;
    @(negedge clk_i);
    btn_i = b;
    sb.push_back(exp_v);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    check_now(tag, e);
  endtask

  task automatic press(input int n, input int idle, input string tag);
    for (int e = 0; e < n; e++) cycle(1'b1, exp_at(e, n), $sformatf("%s_e%0d", tag, e));
    cycle(1'b0, exp_at(n, n), $sformatf("%s_rel", tag));
    for (int i = 0; i < idle; i++) cycle(1'b0, 4'b0000, $sformatf("%s_idle%0d", tag, i));
  endtask

  initial begin
    // Reset held with the button toggling: all outputs stay low.
    for (int i = 0; i < 4; i++) cycle(logic'(i % 2 == 0), 4'b0000, "rst_toggle");
    @(negedge clk_i);
    btn_i = 1'b0;
    rst_i = 1'b0;
    cycle(1'b0, 4'b0000, "post_rst");

    press(5, 2, "short5");
    press(L, 2, "boundary_rel");
    press(L + 1, 2, "long_then_rel");
    press(23, 2, "hold23");
    // Back-to-back presses separated by exactly one low cycle.
    press(3, 0, "b2b_a");
    press(2, 2, "b2b_b");

    // Reset asserted mid-LONG: outputs clear without a clock edge.
    for (int e = 0; e < L + 2; e++) cycle(1'b1, exp_at(e, 100), $sformatf("midlong_e%0d", e));
    #2;
    rst_i = 1'b1;
    #1;
    check_now("async_rst", 4'b0000);
    cycle(1'b1, 4'b0000, "rst_hold_a");

    // Button held while reset deasserts: no event until release and re-press.
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0000, "held_thru_rst");
    cycle(1'b0, 4'b0000, "held_release");
    press(2, 2, "after_held");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
